// File: rtl/sort_sequencer.sv
// Serial-load, four-entry odd-even transposition sorter with a held result handshake.
// Four numbers arrive over valid/ready, are sorted in four single-phase steps, then held until acked.
module sort_sequencer #(
  parameter int W       = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] num_in,
  input  logic         num_valid,
  output logic         num_ready,
  input  logic         display_ack,
  output logic [W-1:0] sorted_num0,
  output logic [W-1:0] sorted_num1,
  output logic [W-1:0] sorted_num2,
  output logic [W-1:0] sorted_num3,
  output logic         start_display,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

  state_t       state;
  state_t       next_state;
  logic [W-1:0] work [4];
  logic [W-1:0] step [4];
  logic [1:0]   load_idx;
  logic [1:0]   phase_cnt;
  logic         xfer;

  // Strictly out of order only, so equal values never move.
  function automatic logic out_of_order(input logic [W-1:0] a, input logic [W-1:0] b);
    return DESCEND ? (a < b) : (a > b);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) step[i] = work[i];
    if (!phase_cnt[0]) begin
      if (out_of_order(work[0], work[1])) begin
        step[0] = work[1];
        step[1] = work[0];
      end
      if (out_of_order(work[2], work[3])) begin
        step[2] = work[3];
        step[3] = work[2];
      end
    end else begin
      if (out_of_order(work[1], work[2])) begin
        step[1] = work[2];
        step[2] = work[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (xfer) next_state = LOAD;
      LOAD:    if (xfer && load_idx == 2'd3) next_state = SORT;
      SORT:    if (phase_cnt == 2'd3) next_state = DONE;
      DONE:    if (display_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    num_ready = (state == IDLE) || (state == LOAD);
    busy      = (state == SORT);
    xfer      = num_valid && num_ready;
  end

  // Datapath registers; the final phase result goes straight to the outputs on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) work[i] <= '0;
      load_idx      <= 2'd0;
      phase_cnt     <= 2'd0;
      sorted_num0   <= '0;
      sorted_num1   <= '0;
      sorted_num2   <= '0;
      sorted_num3   <= '0;
      start_display <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            work[0]  <= num_in;
            load_idx <= 2'd1;
          end
        end
        LOAD: begin
          if (xfer) begin
            work[load_idx] <= num_in;
            load_idx       <= load_idx + 2'd1;
            if (load_idx == 2'd3) phase_cnt <= 2'd0;
          end
        end
        SORT: begin
          for (int i = 0; i < 4; i++) work[i] <= step[i];
          phase_cnt <= phase_cnt + 2'd1;
          if (phase_cnt == 2'd3) begin
            sorted_num0   <= step[0];
            sorted_num1   <= step[1];
            sorted_num2   <= step[2];
            sorted_num3   <= step[3];
            start_display <= 1'b1;
          end
        end
        DONE: begin
          if (display_ack) start_display <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Scoreboard bench: ascending and descending instances share stimulus; monitors pop expected results.
module tb_sort_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       num_valid;
  logic       display_ack;
  logic [3:0] num_in;

  logic       a_ready, a_start, a_busy;
  logic [3:0] a_s0, a_s1, a_s2, a_s3;
  logic       d_ready, d_start, d_busy;
  logic [3:0] d_s0, d_s1, d_s2, d_s3;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_a [$];
  logic [15:0] exp_d [$];
  logic        prev_a = 1'b0;
  logic        prev_d = 1'b0;

  always #5 clk = ~clk;

  sort_sequencer #(.W(4), .DESCEND(1'b0)) dut_asc (
    .clk(clk), .rst(rst), .num_in(num_in), .num_valid(num_valid), .num_ready(a_ready),
    .display_ack(display_ack), .sorted_num0(a_s0), .sorted_num1(a_s1),
    .sorted_num2(a_s2), .sorted_num3(a_s3), .start_display(a_start), .busy(a_busy)
  );

  sort_sequencer #(.W(4), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .rst(rst), .num_in(num_in), .num_valid(num_valid), .num_ready(d_ready),
    .display_ack(display_ack), .sorted_num0(d_s0), .sorted_num1(d_s1),
    .sorted_num2(d_s2), .sorted_num3(d_s3), .start_display(d_start), .busy(d_busy)
  );

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h need %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %b need %b", name, act, req);
    end
  endtask

  // Monitors: each rising start_display must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (a_start && !prev_a) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL asc_unexpected_result: got %h need none", {a_s0, a_s1, a_s2, a_s3});
      end else begin
        e = exp_a.pop_front();
        check_word("asc_result", {a_s0, a_s1, a_s2, a_s3}, e);
      end
    end
    if (d_start && !prev_d) begin
      if (exp_d.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL desc_unexpected_result: got %h need none", {d_s0, d_s1, d_s2, d_s3});
      end else begin
        e = exp_d.pop_front();
        check_word("desc_result", {d_s0, d_s1, d_s2, d_s3}, e);
      end
    end
    prev_a <= a_start;
    prev_d <= d_start;
  end

  task automatic check_reset_state();
    check_word("rst_asc_sorted", {a_s0, a_s1, a_s2, a_s3}, 16'h0000);
    check_word("rst_desc_sorted", {d_s0, d_s1, d_s2, d_s3}, 16'h0000);
    check_bit("rst_asc_start", a_start, 1'b0);
    check_bit("rst_desc_start", d_start, 1'b0);
    check_bit("rst_asc_busy", a_busy, 1'b0);
    check_bit("rst_asc_ready", a_ready, 1'b1);
    check_bit("rst_desc_ready", d_ready, 1'b1);
  endtask

  // Feeds four nibbles (vals[15:12] first); gap idle cycles between values, optional ack pulse in a gap.
  task automatic apply_stimulus(input logic [15:0] vals, input logic [15:0] ea, input logic [15:0] ed,
                                input int gap, input bit ack_in_load, input bit hold_valid,
                                input bit push);
    if (push) begin
      exp_a.push_back(ea);
      exp_d.push_back(ed);
    end
    for (int i = 0; i < 4; i++) begin
      num_in    = vals[15-4*i -: 4];
      num_valid = 1'b1;
      @(posedge clk); #1;
      if (gap > 0 && i < 3) begin
        num_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (ack_in_load && g == 1) display_ack = 1'b1;
          @(negedge clk);
          check_bit("gap_ready", a_ready, 1'b1);
          check_bit("gap_busy", a_busy, 1'b0);
          @(posedge clk); #1;
          display_ack = 1'b0;
        end
      end
    end
    if (hold_valid) num_in = 4'd5;
    else            num_valid = 1'b0;
  endtask

  // Four SORT cycles with busy high and ready low, then start_display exactly on the 4th edge.
  task automatic check_output(input bit ack_in_sort);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("sort_busy", a_busy, 1'b1);
      check_bit("sort_ready", a_ready, 1'b0);
      check_bit("sort_start_early", a_start, 1'b0);
      check_bit("sort_desc_busy", d_busy, 1'b1);
      if (ack_in_sort && k == 2) display_ack = 1'b1;
      @(posedge clk); #1;
      display_ack = 1'b0;
    end
    check_bit("done_asc_start", a_start, 1'b1);
    check_bit("done_desc_start", d_start, 1'b1);
    check_bit("done_busy", a_busy, 1'b0);
    check_bit("done_ready", a_ready, 1'b0);
  endtask

  task automatic do_ack(input logic [15:0] ea, input logic [15:0] ed, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_bit("done_hold_start", a_start, 1'b1);
      check_bit("done_hold_ready", a_ready, 1'b0);
      check_word("done_hold_vals", {a_s0, a_s1, a_s2, a_s3}, ea);
    end
    display_ack = 1'b1;
    @(posedge clk); #1;
    display_ack = 1'b0;
    check_bit("ack_asc_start", a_start, 1'b0);
    check_bit("ack_desc_start", d_start, 1'b0);
    check_bit("ack_ready", a_ready, 1'b1);
    check_bit("ack_busy", a_busy, 1'b0);
    check_word("ack_asc_retained", {a_s0, a_s1, a_s2, a_s3}, ea);
    check_word("ack_desc_retained", {d_s0, d_s1, d_s2, d_s3}, ed);
  endtask

  initial begin
    rst         = 1'b1;
    num_valid   = 1'b0;
    display_ack = 1'b0;
    num_in      = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // 9,3,7,1 then num_valid held high with 5 through SORT/DONE
    apply_stimulus(16'h9371, 16'h1379, 16'h9731, 0, 1'b0, 1'b1, 1'b1);
    check_output(1'b0);
    do_ack(16'h1379, 16'h9731, 3);

    // The held 5 is the first value accepted after the ack
    apply_stimulus(16'h5628, 16'h2568, 16'h8652, 0, 1'b0, 1'b0, 1'b1);
    check_output(1'b0);
    do_ack(16'h2568, 16'h8652, 0);

    // Duplicates, with an ack pulse during SORT
    apply_stimulus(16'h4424, 16'h2444, 16'h4442, 0, 1'b0, 1'b0, 1'b1);
    check_output(1'b1);
    do_ack(16'h2444, 16'h4442, 1);

    apply_stimulus(16'h0F8F, 16'h08FF, 16'hFF80, 0, 1'b0, 1'b0, 1'b1);
    check_output(1'b0);
    do_ack(16'h08FF, 16'hFF80, 0);

    // Gapped load with an ack pulse during LOAD
    apply_stimulus(16'hFEDC, 16'hCDEF, 16'hFEDC, 3, 1'b1, 1'b0, 1'b1);
    check_output(1'b0);
    do_ack(16'hCDEF, 16'hFEDC, 0);

    // Reset on the 2nd SORT cycle aborts the sort
    apply_stimulus(16'h6543, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    repeat (6) @(posedge clk);
    #1;
    check_bit("abort_no_start", a_start, 1'b0);
    check_bit("abort_idle_ready", a_ready, 1'b1);

    apply_stimulus(16'h2130, 16'h0123, 16'h3210, 0, 1'b0, 1'b0, 1'b1);
    check_output(1'b0);
    do_ack(16'h0123, 16'h3210, 0);

    @(negedge clk);
    @(negedge clk);
    check_word("asc_queue_drained", 16'(exp_a.size()), 16'h0000);
    check_word("desc_queue_drained", 16'(exp_d.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
